// File: rtl/fpu_pkg.sv
// Shared binary32 format constants and field helpers for the FPU datapaths.
package fpu_pkg;

   localparam int FP_BIAS    = 127;
   localparam int FP_EXP_MAX = 255;

   localparam int MANT_W = 23;
   localparam int SIG_W  = 24;
   localparam int Q_W    = 25;
   localparam int EXP_W  = 8;
   localparam int EA_W   = 10;

   localparam int SIGN_POS = 31;
   localparam int EXP_HI   = 30;
   localparam int EXP_LO   = 23;
   localparam int MANT_HI  = 22;

   // Operand classes; subnormals count as zero and NaN encodings as infinity.
   typedef struct packed {
      logic x1_zero;
      logic x1_inf;
      logic x2_zero;
      logic x2_inf;
   } fclass_t;

   function automatic logic fp_sign(input logic [31:0] v);
      return v[SIGN_POS];
   endfunction

   function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] v);
      return v[EXP_HI:EXP_LO];
   endfunction

   function automatic logic [MANT_W-1:0] fp_mant(input logic [31:0] v);
      return v[MANT_HI:0];
   endfunction

endpackage

// File: rtl/fdiv_norm.sv
// Quotient normalization and special-case selection for the divider.
module fdiv_norm
   import fpu_pkg::*;
(
   input  logic [Q_W-1:0]         q,
   input  logic signed [EA_W-1:0] ea,
   input  logic                   s,
   input  fclass_t                cls,
   output logic [31:0]            y,
   output logic                   ovf
);

   localparam logic signed [EA_W-1:0] EA_MAX = EA_W'(FP_EXP_MAX);

   logic signed [EA_W-1:0] e_n;
   logic [MANT_W-1:0]      m_n;

   // Quotient lies in [2^23, 2^25): one-bit normalization, truncating.
   always_comb begin
      if (q[Q_W-1]) begin
         m_n = q[MANT_W:1];
         e_n = ea;
      end else begin
         m_n = q[MANT_W-1:0];
         e_n = ea - 10'sd1;
      end
   end

   // Special operands outrank range checks; divide-by-zero wins over 0/0.
   always_comb begin
      y   = {s, 8'h00, 23'h0};
      ovf = 1'b0;
      if (cls.x2_zero || cls.x1_inf) begin
         y   = {s, 8'hFF, 23'h0};
         ovf = 1'b1;
      end else if (cls.x1_zero || cls.x2_inf) begin
         y   = {s, 8'h00, 23'h0};
      end else if (e_n >= EA_MAX) begin
         y   = {s, 8'hFF, 23'h0};
         ovf = 1'b1;
      end else if (e_n <= 10'sd0) begin
         y   = {s, 8'h00, 23'h0};
      end else begin
         y   = {s, e_n[EXP_W-1:0], m_n};
      end
   end

endmodule

// File: rtl/fdiv_seq.sv
// Iterative binary32 divider: radix-2 restoring, one quotient bit per cycle.
//
//   state  | meaning
//   IDLE   | waiting for start; operands sampled on accept
//   DIV    | 25 restoring steps, cnt 24 down to 0
//   NORM   | register normalized result, pulse valid
module fdiv_seq
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic        busy,
   output logic        valid,
   output logic [31:0] y,
   output logic        ovf
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_NORM = 2'd2;

   logic [1:0]             state;
   logic [Q_W-1:0]         r;
   logic [Q_W-1:0]         q;
   logic [SIG_W-1:0]       m2a;
   logic [4:0]             cnt;
   logic signed [EA_W-1:0] ea;
   logic                   s;
   fclass_t                cls;

   logic [EXP_W-1:0] e1;
   logic [EXP_W-1:0] e2;
   logic [Q_W-1:0]   r_sub;
   logic             r_ge;
   logic [31:0]      y_n;
   logic             ovf_n;

   assign e1    = fp_exp(x1);
   assign e2    = fp_exp(x2);
   assign r_sub = r - {1'b0, m2a};
   assign r_ge  = (r >= {1'b0, m2a});

   fdiv_norm u_norm (
      .q   (q),
      .ea  (ea),
      .s   (s),
      .cls (cls),
      .y   (y_n),
      .ovf (ovf_n)
   );

   // Handshake FSM and restoring-division datapath. The loop runs for special
   // operands too so latency never depends on the data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         valid <= 1'b0;
         y     <= '0;
         ovf   <= 1'b0;
         r     <= '0;
         q     <= '0;
         m2a   <= '0;
         cnt   <= '0;
         ea    <= '0;
         s     <= 1'b0;
         cls   <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  s     <= fp_sign(x1) ^ fp_sign(x2);
                  r     <= {2'b01, fp_mant(x1)};
                  m2a   <= {1'b1, fp_mant(x2)};
                  ea    <= EA_W'({2'b00, e1}) - EA_W'({2'b00, e2}) + EA_W'(FP_BIAS);
                  cls   <= '{x1_zero: (e1 == 8'h00), x1_inf: (e1 == 8'hFF),
                             x2_zero: (e2 == 8'h00), x2_inf: (e2 == 8'hFF)};
                  q     <= '0;
                  cnt   <= 5'(Q_W - 1);
                  busy  <= 1'b1;
                  state <= S_DIV;
               end
            end
            S_DIV: begin
               // q fills MSB-first by shifting, equivalent to setting q[cnt].
               if (r_ge) begin
                  q <= {q[Q_W-2:0], 1'b1};
                  r <= r_sub << 1;
               end else begin
                  q <= {q[Q_W-2:0], 1'b0};
                  r <= r << 1;
               end
               cnt <= cnt - 5'd1;
               if (cnt == 5'd0) state <= S_NORM;
            end
            S_NORM: begin
               y     <= y_n;
               ovf   <= ovf_n;
               valid <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq plus a short random sweep against a division model.
module tb_fdiv_seq;

   logic        clk;
   logic        rstn;
   logic        start;
   logic [31:0] x1;
   logic [31:0] x2;
   logic        busy;
   logic        valid;
   logic [31:0] y;
   logic        ovf;

   int compared   = 0;
   int mismatched = 0;

   fdiv_seq dut (
      .clk   (clk),
      .rstn  (rstn),
      .start (start),
      .x1    (x1),
      .x2    (x2),
      .busy  (busy),
      .valid (valid),
      .y     (y),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: exact integer division of the significands, then the same
   // normalization/flush rules applied to the arithmetic result.
   function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      int          ea_i;
      int          eb_i;
      int          e;
      logic        sg;
      logic [63:0] ma;
      logic [63:0] mb;
      logic [63:0] qq;
      logic [22:0] m;
      ea_i = int'(a[30:23]);
      eb_i = int'(b[30:23]);
      sg   = a[31] ^ b[31];
      if (eb_i == 0 || ea_i == 255) return {1'b1, sg, 8'hFF, 23'h0};
      if (ea_i == 0 || eb_i == 255) return {1'b0, sg, 8'h00, 23'h0};
      ma = {40'h0, 1'b1, a[22:0]};
      mb = {40'h0, 1'b1, b[22:0]};
      qq = (ma << 24) / mb;
      e  = ea_i - eb_i + 127;
      if (qq >= 64'h100_0000) m = qq[23:1];
      else begin
         m = qq[22:0];
         e = e - 1;
      end
      if (e >= 255) return {1'b1, sg, 8'hFF, 23'h0};
      if (e <= 0)   return {1'b0, sg, 8'h00, 23'h0};
      return {1'b0, sg, e[7:0], m};
   endfunction

   // Issue one divide, measure latency and busy span, check the result.
   task automatic run(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ey, input logic eo, input string tag);
      int lat;
      int bcnt;
      @(negedge clk);
      x1 = a; x2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bcnt = busy ? 1 : 0;
      lat  = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (valid) begin
            lat = k;
            break;
         end
         if (busy) bcnt++;
      end
      check({tag, " latency"}, 32'(lat), 32'd26);
      check({tag, " busy span"}, 32'(bcnt), 32'd26);
      check({tag, " busy at valid"}, {31'h0, busy}, 32'h0);
      check({tag, " y"}, y, ey);
      check({tag, " ovf"}, {31'h0, ovf}, {31'h0, eo});
      @(posedge clk); #1;
      check({tag, " valid one cycle"}, {31'h0, valid}, 32'h0);
   endtask

   initial begin
      int          vcnt;
      int          lat;
      logic [31:0] yfirst;
      logic [32:0] r;
      logic [31:0] a;
      logic [31:0] b;

      rstn = 1'b0; start = 1'b0; x1 = '0; x2 = '0;
      #12;
      check("reset busy",  {31'h0, busy},  32'h0);
      check("reset valid", {31'h0, valid}, 32'h0);
      check("reset y",     y,              32'h0);
      check("reset ovf",   {31'h0, ovf},   32'h0);
      @(negedge clk); rstn = 1'b1;

      run(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, "6/2");
      run(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, "1/3");
      run(32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, "-6/2");
      run(32'h40E00000, 32'h40000000, 32'h40600000, 1'b0, "7/2");
      run(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, "max/1");
      run(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, "1/0");
      run(32'h00000000, 32'h40000000, 32'h00000000, 1'b0, "0/2");
      run(32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, "overflow");
      run(32'h00800000, 32'h40000000, 32'h00000000, 1'b0, "underflow");
      run(32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, "0/0");
      run(32'h7F800000, 32'h40000000, 32'h7F800000, 1'b1, "inf/2");
      run(32'h40000000, 32'h7F800000, 32'h00000000, 1'b0, "2/inf");
      run(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, "-1/0");

      // start held with changing operands while busy must be ignored
      @(negedge clk);
      x1 = 32'h40C00000; x2 = 32'h40000000; start = 1'b1;
      @(posedge clk); #1;
      vcnt = 0; lat = 0; yfirst = '0;
      for (int k = 1; k <= 60; k++) begin
         if (k <= 10) begin
            start = 1'b1;
            x1 = 32'h3F800000 + 32'(k);
            x2 = 32'h40400000;
         end else start = 1'b0;
         @(posedge clk); #1;
         if (valid) begin
            vcnt++;
            if (vcnt == 1) begin
               lat = k;
               yfirst = y;
            end
         end
      end
      check("ignore start valid count", 32'(vcnt), 32'd1);
      check("ignore start latency", 32'(lat), 32'd26);
      check("ignore start y", yfirst, 32'h40400000);

      // start raised in the valid cycle is accepted at the next edge
      @(negedge clk);
      x1 = 32'h3F800000; x2 = 32'h40400000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (valid) begin
            lat = k;
            break;
         end
      end
      check("b2b first latency", 32'(lat), 32'd26);
      check("b2b first y", y, 32'h3EAAAAAA);
      x1 = 32'h40C00000; x2 = 32'h40000000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b accepted busy", {31'h0, busy}, 32'h1);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (valid) begin
            lat = k;
            break;
         end
      end
      check("b2b second latency", 32'(lat), 32'd26);
      check("b2b second y", y, 32'h40400000);

      // reset in the middle of a divide
      run(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, "pre-reset 1/0");
      @(negedge clk);
      x1 = 32'h40C00000; x2 = 32'h40000000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (12) @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("midreset busy",  {31'h0, busy},  32'h0);
      check("midreset valid", {31'h0, valid}, 32'h0);
      check("midreset y",     y,              32'h0);
      check("midreset ovf",   {31'h0, ovf},   32'h0);
      @(negedge clk); rstn = 1'b1;
      vcnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (valid) vcnt++;
      end
      check("no stale valid", 32'(vcnt), 32'd0);
      run(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, "post-reset 6/2");

      // random sweep on normal operands
      for (int i = 0; i < 200; i++) begin
         a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
         b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
         r = ref_div(a, b);
         run(a, b, r[31:0], r[32], "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
